encoder_level: RTL and testbench

//  Turns a raw mechanical quadrature rotary encoder (A/B contacts) into a WIDTH-bit

---
 rtl/encoder_level.sv | 189 ++++++++++++++++++
 tb/tb_encoder_level.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_level.sv
// encoder_level: mechanical quadrature encoder (A/B) to WIDTH-bit level register.
// The raw contacts pass through a two-flop synchroniser and a per-channel debouncer.
// The level steps once per rising edge of debounced A (x1 decode). The direction is
// taken from debounced B as it stood in the cycle before that edge.
// Three INIT cycles after reset load the debouncers from the inputs, so an encoder
// that is resting with A=1 does not produce a step.
module encoder_level #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STEP            = 1,
  parameter bit          SATURATE        = 1'b1,
  parameter int unsigned RESET_LEVEL     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level,
  output logic             changed
);

  localparam int unsigned      CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] LVL_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LVL_STEP  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LVL_RESET = WIDTH'(RESET_LEVEL);
  localparam logic [1:0]       INIT_LAST = 2'd2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One debounce sample: returns {accepted value, counter}.
  function automatic logic [CW:0] deb_step(input logic sample, input logic deb,
                                           input logic [CW-1:0] cnt);
    logic [CW:0] r;
    if (sample == deb) begin
      r = {deb, {CW{1'b0}}};
    end else if (cnt == CNT_LAST) begin
      r = {sample, {CW{1'b0}}};
    end else begin
      r = {deb, cnt + CNT_ONE};
    end
    return r;
  endfunction

  // Level after one detent clockwise.
  function automatic logic [WIDTH-1:0] level_up(input logic [WIDTH-1:0] lv);
    logic [WIDTH-1:0] r;
    if (SATURATE && (lv > (LVL_MAX - LVL_STEP))) begin
      r = LVL_MAX;
    end else begin
      r = lv + LVL_STEP;
    end
    return r;
  endfunction

  // Level after one detent counter-clockwise.
  function automatic logic [WIDTH-1:0] level_down(input logic [WIDTH-1:0] lv);
    logic [WIDTH-1:0] r;
    if (SATURATE && (lv < LVL_STEP)) begin
      r = {WIDTH{1'b0}};
    end else begin
      r = lv - LVL_STEP;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       init_cnt_q, init_cnt_d;
  logic [1:0]       sync1_q, sync1_d;   // bit 0 = A, bit 1 = B
  logic [1:0]       sync2_q, sync2_d;
  logic             deb_a_q, deb_a_d;
  logic             deb_b_q, deb_b_d;
  logic [CW-1:0]    cnt_a_q, cnt_a_d;
  logic [CW-1:0]    cnt_b_q, cnt_b_d;
  logic             deb_a_dly_q, deb_a_dly_d;
  logic             deb_b_dly_q, deb_b_dly_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             changed_q, changed_d;
  logic             init_s;
  logic             run_s;
  logic             step_s;

  // State register and all datapath flops; reset wins and cancels any pending step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= 2'd0;
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      deb_a_q     <= 1'b0;
      deb_b_q     <= 1'b0;
      cnt_a_q     <= {CW{1'b0}};
      cnt_b_q     <= {CW{1'b0}};
      deb_a_dly_q <= 1'b0;
      deb_b_dly_q <= 1'b0;
      level_q     <= LVL_RESET;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_a_q     <= deb_a_d;
      deb_b_q     <= deb_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      deb_a_dly_q <= deb_a_dly_d;
      deb_b_dly_q <= deb_b_dly_d;
      level_q     <= level_d;
      changed_q   <= changed_d;
    end
  end

  // Next state: INIT holds for exactly three cycles, then RUN until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = 2'd0;
        end else begin
          state_d    = ST_INIT;
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        state_d    = ST_RUN;
        init_cnt_d = 2'd0;
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = 2'd0;
      end
    endcase
  end

  // FSM outputs: INIT preloads the debouncers, RUN enables decode.
  always_comb begin
    init_s = 1'b0;
    run_s  = 1'b0;
    case (state_q)
      ST_INIT: init_s = 1'b1;
      ST_RUN:  run_s  = 1'b1;
      default: init_s = 1'b1;
    endcase
  end

  // Synchronise, debounce, detect the debounced A rise and update the level.
  always_comb begin
    sync1_d = {enc_b, enc_a};
    sync2_d = sync1_q;
    if (init_s) begin
      // The edge-detect delays load the same value so RUN starts with no edge.
      deb_a_d     = sync2_q[0];
      deb_b_d     = sync2_q[1];
      cnt_a_d     = {CW{1'b0}};
      cnt_b_d     = {CW{1'b0}};
      deb_a_dly_d = sync2_q[0];
      deb_b_dly_d = sync2_q[1];
    end else begin
      {deb_a_d, cnt_a_d} = deb_step(sync2_q[0], deb_a_q, cnt_a_q);
      {deb_b_d, cnt_b_d} = deb_step(sync2_q[1], deb_b_q, cnt_b_q);
      deb_a_dly_d = deb_a_q;
      deb_b_dly_d = deb_b_q;
    end

    step_s = run_s & deb_a_q & ~deb_a_dly_q;
    if (step_s) begin
      if (deb_b_dly_q) begin
        level_d = level_down(level_q);
      end else begin
        level_d = level_up(level_q);
      end
    end else begin
      level_d = level_q;
    end
    changed_d = (level_d != level_q);
  end

  assign level   = level_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_encoder_level.sv
// Directed bench for encoder_level: four instances share the encoder inputs.
//   u0: defaults (STEP 1, saturating, reset level 0)
//   u1: STEP 16, saturating, reset level 250
//   u2: STEP 16, saturating, reset level 5
//   u3: STEP 1, wrapping, reset level 255
module tb_encoder_level;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] level0, level1, level2, level3;
  logic       changed0, changed1, changed2, changed3;

  int vectors = 0;
  int errors  = 0;
  int exp0;
  int nxt;

  always #5 clk = ~clk;

  encoder_level u0 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level0), .changed(changed0)
  );

  encoder_level #(.STEP(16), .RESET_LEVEL(250)) u1 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level1), .changed(changed1)
  );

  encoder_level #(.STEP(16), .RESET_LEVEL(5)) u2 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level2), .changed(changed2)
  );

  encoder_level #(.SATURATE(1'b0), .RESET_LEVEL(255)) u3 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level3), .changed(changed3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input int e0, input int e1, input int e2, input int e3,
                           input int c0, input int c1, input int c2, input int c3);
    chk({tag, " level0"},   32'(level0),   e0);
    chk({tag, " level1"},   32'(level1),   e1);
    chk({tag, " level2"},   32'(level2),   e2);
    chk({tag, " level3"},   32'(level3),   e3);
    chk({tag, " changed0"}, 32'(changed0), c0);
    chk({tag, " changed1"}, 32'(changed1), c1);
    chk({tag, " changed2"}, 32'(changed2), c2);
    chk({tag, " changed3"}, 32'(changed3), c3);
  endtask

  initial begin
    // Reset with the encoder resting at A=1, B=1.
    reset = 1'b1;
    enc_a = 1'b1;
    enc_b = 1'b1;
    tick();
    tick();
    check_all("reset", 0, 250, 5, 255, 0, 0, 0, 0);
    reset = 1'b0;

    // INIT must absorb A=1 without stepping.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("init_hold", 0, 250, 5, 255, 0, 0, 0, 0);
    end

    // Falling A and falling B: no step.
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (12) tick();
    check_all("a_b_fall", 0, 250, 5, 255, 0, 0, 0, 0);

    // Clean A rise with B=0: up, applied at the 7th edge.
    enc_a = 1'b1;
    repeat (6) tick();
    check_all("up_e6", 0, 250, 5, 255, 0, 0, 0, 0);
    tick();
    check_all("up_e7", 1, 255, 21, 0, 1, 1, 1, 1);
    tick();
    check_all("up_e8", 1, 255, 21, 0, 0, 0, 0, 0);
    enc_a = 1'b0;
    repeat (10) tick();

    // B rise alone does not step; then A rise with B=1: down.
    enc_b = 1'b1;
    repeat (10) tick();
    check_all("b_rise", 1, 255, 21, 0, 0, 0, 0, 0);
    enc_a = 1'b1;
    repeat (6) tick();
    check_all("dn_e6", 1, 255, 21, 0, 0, 0, 0, 0);
    tick();
    check_all("dn_e7", 0, 239, 5, 255, 1, 1, 1, 1);
    tick();
    check_all("dn_e8", 0, 239, 5, 255, 0, 0, 0, 0);
    enc_a = 1'b0;
    repeat (10) tick();

    // Second down: u0 held at 0, u2 clamps 5 -> 0.
    enc_a = 1'b1;
    repeat (7) tick();
    check_all("dn2_e7", 0, 223, 0, 254, 0, 1, 1, 1);
    enc_a = 1'b0;
    repeat (10) tick();
    enc_b = 1'b0;
    repeat (10) tick();

    // A 3-cycle pulse is shorter than the debounce window.
    enc_a = 1'b1;
    repeat (3) tick();
    enc_a = 1'b0;
    repeat (12) tick();
    check_all("pulse3", 0, 223, 0, 254, 0, 0, 0, 0);

    // Bounce 1,0,1,0 (2 cycles each), then settle at 1: exactly one up step.
    enc_a = 1'b1; repeat (2) tick();
    enc_a = 1'b0; repeat (2) tick();
    enc_a = 1'b1; repeat (2) tick();
    enc_a = 1'b0; repeat (2) tick();
    enc_a = 1'b1;
    repeat (6) tick();
    check_all("bounce_e6", 0, 223, 0, 254, 0, 0, 0, 0);
    tick();
    check_all("bounce_e7", 1, 239, 16, 255, 1, 1, 1, 1);
    enc_a = 1'b0;
    repeat (10) tick();
    check_all("bounce_end", 1, 239, 16, 255, 0, 0, 0, 0);

    // 260 up detents: u0 clamps at 255 and stops pulsing changed.
    exp0 = 1;
    for (int i = 0; i < 260; i++) begin
      enc_a = 1'b1;
      repeat (7) tick();
      nxt = (exp0 == 255) ? 255 : exp0 + 1;
      chk("sat_level0", 32'(level0), nxt);
      chk("sat_changed0", 32'(changed0), (nxt != exp0) ? 1 : 0);
      exp0 = nxt;
      enc_a = 1'b0;
      repeat (7) tick();
    end
    check_all("sat_end", 255, 255, 255, 3, 0, 0, 0, 0);

    // Reset two cycles after an A rise aborts the pending step.
    enc_a = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_all("mid_reset", 0, 250, 5, 255, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("post_reset", 0, 250, 5, 255, 0, 0, 0, 0);
    end

    // Decoding resumes normally afterwards.
    enc_a = 1'b0;
    repeat (10) tick();
    enc_a = 1'b1;
    repeat (7) tick();
    check_all("resume", 1, 255, 21, 0, 1, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
